cgra_context_sequencer: RTL and testbench

CGRA_CONTEXT_SEQUENCER -- requirements
Module: cgra_context_sequencer

---
 rtl/cgra_context_sequencer_if.sv | 38 +++
 rtl/cgra_context_sequencer.sv | 140 ++++++++++++++
 tb/tb_cgra_context_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_context_sequencer_if.sv
// Sequencer-side bundle: run control, PE strobes and config-memory read port.
// master = sequencer, slave = PE / memory / host environment.
interface cgra_context_sequencer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int LOOP_WIDTH = 16
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH:0]   num_contexts;
  logic [LOOP_WIDTH-1:0] loop_count;
  logic                  advance;
  logic                  cfg_rd_en;
  logic [ADDR_WIDTH-1:0] cfg_rd_addr;
  logic [DATA_WIDTH-1:0] cfg_rd_data;
  logic                  cfg_rd_valid;
  logic [DATA_WIDTH-1:0] active_cfg;
  logic                  cfg_valid;
  logic [ADDR_WIDTH-1:0] context_pc;
  logic [LOOP_WIDTH-1:0] iter_count;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  start, abort, num_contexts, loop_count, advance,
    input  cfg_rd_data, cfg_rd_valid,
    output cfg_rd_en, cfg_rd_addr, active_cfg, cfg_valid,
    output context_pc, iter_count, busy, done, err
  );

  modport slave (
    output start, abort, num_contexts, loop_count, advance,
    output cfg_rd_data, cfg_rd_valid,
    input  cfg_rd_en, cfg_rd_addr, active_cfg, cfg_valid,
    input  context_pc, iter_count, busy, done, err
  );
endinterface

// File: rtl/cgra_context_sequencer.sv
// Steps a PE through a run of config slots, fetching each frame from
// config memory and repeating the slot list loop_count times (0 = forever).
module cgra_context_sequencer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int LOOP_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  cgra_context_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  state_e                state_q;
  logic [ADDR_WIDTH:0]   num_q;
  logic [LOOP_WIDTH-1:0] loop_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [LOOP_WIDTH-1:0] iter_q;
  logic [DATA_WIDTH-1:0] cfg_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_en_q;
  logic                  cfg_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] pc_d;
  logic [LOOP_WIDTH-1:0] iter_d;
  logic                  last_slot;
  logic                  nc_ok;
  logic                  finish;

  assign pc_d      = pc_q + ADDR_WIDTH'(1);
  assign iter_d    = iter_q + LOOP_WIDTH'(1);
  assign last_slot = ({1'b0, pc_q} == (num_q - ONE_W));
  assign nc_ok     = (bus.num_contexts != '0) &&
                     (bus.num_contexts <= DEPTH_W);
  assign finish    = (loop_q != '0) && (iter_d == loop_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      loop_q      <= '0;
      pc_q        <= '0;
      iter_q      <= '0;
      cfg_q       <= '0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (bus.abort) begin
      // progress registers are kept so the host can see how far it got
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && nc_ok) begin
            num_q     <= bus.num_contexts;
            loop_q    <= bus.loop_count;
            pc_q      <= '0;
            iter_q    <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_FETCH;
          end else if (bus.start) begin
            err_q <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (bus.cfg_rd_valid) begin
            cfg_q       <= bus.cfg_rd_data;
            cfg_valid_q <= 1'b1;
            state_q     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.advance) begin
            cfg_valid_q <= 1'b0;
            if (!last_slot) begin
              pc_q      <= pc_d;
              rd_addr_q <= pc_d;
              rd_en_q   <= 1'b1;
              state_q   <= S_FETCH;
            end else begin
              iter_q <= iter_d;
              if (finish) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                pc_q      <= '0;
                rd_addr_q <= '0;
                rd_en_q   <= 1'b1;
                state_q   <= S_FETCH;
              end
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_rd_en   = rd_en_q;
  assign bus.cfg_rd_addr = rd_addr_q;
  assign bus.active_cfg  = cfg_q;
  assign bus.cfg_valid   = cfg_valid_q;
  assign bus.context_pc  = pc_q;
  assign bus.iter_count  = iter_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_cgra_context_sequencer.sv
// Directed and randomized checks of cgra_context_sequencer against a
// slot/iteration model and a 1-cycle config memory.
module tb_cgra_context_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cgra_context_sequencer_if #(
    .DATA_WIDTH(64), .ADDR_WIDTH(4), .LOOP_WIDTH(16)
  ) bus ();

  cgra_context_sequencer #(
    .DATA_WIDTH(64), .DEPTH(16), .ADDR_WIDTH(4), .LOOP_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] mem [16];
  logic        mute       = 1'b0;
  logic        force_rv   = 1'b0;
  logic [63:0] force_data = '0;
  logic        mem_en;
  logic [3:0]  mem_a;

  // config memory: answers one cycle after cfg_rd_en
  always @(posedge clk) begin
    mem_en = bus.cfg_rd_en;
    mem_a  = bus.cfg_rd_addr;
    #1;
    bus.cfg_rd_valid = mute ? force_rv : mem_en;
    bus.cfg_rd_data  = mute ? force_data : mem[mem_a];
  end

  logic [3:0] rd_log [$];
  int done_cnt = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (bus.cfg_rd_en === 1'b1) rd_log.push_back(bus.cfg_rd_addr);
    if (bus.done === 1'b1) done_cnt++;
    if (bus.err === 1'b1) err_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int nc, input int lc);
    bus.num_contexts = 5'(nc);
    bus.loop_count   = 16'(lc);
    bus.start        = 1'b1;
    tick(1);
    bus.start        = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (bus.cfg_valid !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    ok = (bus.cfg_valid === 1'b1);
    chk("wait_cfg_valid", {63'd0, bus.cfg_valid}, 64'd1);
  endtask

  task automatic pulse_advance();
    bus.advance = 1'b1;
    tick(1);
    bus.advance = 1'b0;
  endtask

  // lc!=0: full run to DONE; lc==0: run iters loops then abort
  task automatic do_run(input string tag, input int nc, input int lc,
                        input int iters, input bit rnd, input bit poke);
    logic [3:0] exp_addr [$];
    int  done0, err0, gap, ns;
    bit  ok;
    rd_log.delete();
    done0 = done_cnt;
    err0  = err_cnt;
    for (int it = 0; it < iters; it++)
      for (int s = 0; s < nc; s++) exp_addr.push_back(4'(s));
    ns = exp_addr.size();
    if (lc == 0) exp_addr.push_back(4'd0);
    start_run(nc, lc);
    for (int k = 0; k < ns; k++) begin
      wait_valid(ok);
      if (!ok) break;
      chk({tag, "_cfg"}, bus.active_cfg, mem[exp_addr[k]]);
      chk({tag, "_pc"}, 64'(bus.context_pc), 64'(exp_addr[k]));
      chk({tag, "_iter"}, 64'(bus.iter_count), 64'(k / nc));
      if (poke && k == 0) begin
        bus.num_contexts = 5'd3;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
      end
      gap = rnd ? int'($urandom_range(0, 3)) : 2;
      tick(gap);
      pulse_advance();
      chk({tag, "_vfall"}, {63'd0, bus.cfg_valid}, 64'd0);
    end
    if (lc != 0) begin
      chk({tag, "_done_hi"}, {63'd0, bus.done}, 64'd1);
      chk({tag, "_busy_hi"}, {63'd0, bus.busy}, 64'd1);
      tick(1);
      chk({tag, "_done_lo"}, {63'd0, bus.done}, 64'd0);
      chk({tag, "_busy_lo"}, {63'd0, bus.busy}, 64'd0);
      chk({tag, "_pc_end"}, 64'(bus.context_pc), 64'(nc - 1));
      chk({tag, "_cfg_end"}, bus.active_cfg, mem[nc-1]);
    end else begin
      chk({tag, "_wrap_rd"}, {63'd0, bus.cfg_rd_en}, 64'd1);
      bus.abort = 1'b1;
      tick(1);
      bus.abort = 1'b0;
      chk({tag, "_ab_busy"}, {63'd0, bus.busy}, 64'd0);
      chk({tag, "_ab_vld"}, {63'd0, bus.cfg_valid}, 64'd0);
      chk({tag, "_ab_rd"}, {63'd0, bus.cfg_rd_en}, 64'd0);
    end
    chk({tag, "_iter_end"}, 64'(bus.iter_count), 64'(iters));
    tick(2);
    chk({tag, "_nrd"}, 64'(rd_log.size()), 64'(exp_addr.size()));
    for (int i = 0; i < rd_log.size() && i < exp_addr.size(); i++)
      chk({tag, "_addr"}, 64'(rd_log[i]), 64'(exp_addr[i]));
    chk({tag, "_ndone"}, 64'(done_cnt - done0), 64'(lc != 0));
    chk({tag, "_nerr"}, 64'(err_cnt - err0), 64'd0);
  endtask

  initial begin
    bit ok;
    int nc, lc;
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.advance = 1'b0;
    bus.num_contexts = '0;
    bus.loop_count = '0;
    tick(3);
    chk("rst_cfg", bus.active_cfg, 64'd0);
    chk("rst_pc", 64'(bus.context_pc), 64'd0);
    chk("rst_iter", 64'(bus.iter_count), 64'd0);
    chk("rst_flags", {57'd0, bus.cfg_rd_en, bus.cfg_valid, bus.busy,
        bus.done, bus.err, 2'b00}, 64'd0);
    chk("rst_addr", 64'(bus.cfg_rd_addr), 64'd0);
    rst = 1'b0;
    tick(1);

    do_run("three_ctx", 3, 1, 1, 1'b0, 1'b0);
    do_run("two_by3", 2, 3, 3, 1'b0, 1'b0);

    rd_log.delete();
    start_run(0, 1);
    chk("err0_pulse", {63'd0, bus.err}, 64'd1);
    chk("err0_busy", {63'd0, bus.busy}, 64'd0);
    tick(1);
    chk("err0_once", {63'd0, bus.err}, 64'd0);
    start_run(17, 1);
    chk("err17_pulse", {63'd0, bus.err}, 64'd1);
    chk("err17_busy", {63'd0, bus.busy}, 64'd0);
    tick(2);
    chk("err_no_rd", 64'(rd_log.size()), 64'd0);

    do_run("forever", 1, 0, 5, 1'b0, 1'b0);
    chk("forever_nodone", {63'd0, bus.done}, 64'd0);

    mute = 1'b1;
    start_run(2, 1);
    tick(1);
    force_rv = 1'b1;
    force_data = {$urandom, $urandom} | 64'd1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("wrst_cfg", bus.active_cfg, 64'd0);
    chk("wrst_flags", {59'd0, bus.cfg_rd_en, bus.cfg_valid, bus.busy,
        bus.done, bus.err}, 64'd0);
    tick(2);
    chk("wrst_ignore", bus.active_cfg, 64'd0);
    chk("wrst_vld", {63'd0, bus.cfg_valid}, 64'd0);
    force_rv = 1'b0;
    mute = 1'b0;
    tick(1);

    start_run(3, 1);
    chk("lat_n1_rd", {63'd0, bus.cfg_rd_en}, 64'd1);
    chk("lat_n1_vld", {63'd0, bus.cfg_valid}, 64'd0);
    tick(1);
    chk("lat_n2_rd", {63'd0, bus.cfg_rd_en}, 64'd0);
    chk("lat_n2_vld", {63'd0, bus.cfg_valid}, 64'd0);
    tick(1);
    chk("lat_n3_vld", {63'd0, bus.cfg_valid}, 64'd1);
    chk("lat_n3_cfg", bus.active_cfg, mem[0]);
    bus.advance = 1'b1;
    bus.abort = 1'b1;
    tick(1);
    bus.advance = 1'b0;
    bus.abort = 1'b0;
    chk("advab_busy", {63'd0, bus.busy}, 64'd0);
    chk("advab_vld", {63'd0, bus.cfg_valid}, 64'd0);
    chk("advab_pc", 64'(bus.context_pc), 64'd0);
    tick(3);
    chk("advab_idle", {62'd0, bus.busy, bus.cfg_rd_en}, 64'd0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
      nc = int'($urandom_range(1, 16));
      lc = int'($urandom_range(1, 3));
      do_run("random", nc, lc, lc, 1'b1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
